// File: rtl/eth_rx_frame_filter.sv
// GMII receive frame engine: preamble/SFD detection, Ethernet header parse with
// destination MAC and EtherType filtering, FCS-stripped payload stream, and
// CRC-32 / length checking with the verdict tagged on the last payload beat.
module eth_rx_frame_filter #(
    parameter int unsigned NUM_ETYPES    = 4,
    parameter int unsigned MIN_FRAME_LEN = 64,
    parameter int unsigned MAX_FRAME_LEN = 1518
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [7:0]                gmii_rxd,
    input  logic                      gmii_rx_dv,
    input  logic                      gmii_rx_er,
    input  logic [47:0]               mac_d_addr,
    input  logic                      promisc_en,
    input  logic [16*NUM_ETYPES-1:0]  etype_table,
    output logic [7:0]                m_tdata,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    output logic                      m_tuser,
    output logic [NUM_ETYPES-1:0]     etype_hit,
    output logic [47:0]               rx_src_mac,
    output logic                      frame_ok,
    output logic                      frame_crc_err,
    output logic                      frame_len_err,
    output logic                      frame_drop
);

    localparam logic [13:0] MinLen     = 14'(MIN_FRAME_LEN);
    localparam logic [13:0] MaxLen     = 14'(MAX_FRAME_LEN);
    localparam logic [13:0] LenSat     = 14'h3FFF;
    localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;

    typedef enum logic [2:0] {StIdle, StPreamble, StHeader, StPayload, StDrop} state_e;

    // Reflected CRC-32 update over one byte, LSB first as on the wire.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    state_e                state_q, state_d;
    logic [2:0]            pre_cnt_q, pre_cnt_d;
    logic [3:0]            hdr_cnt_q, hdr_cnt_d;
    logic [47:0]           dest_q, dest_d;
    logic [47:0]           src_q, src_d;
    logic [7:0]            ety_hi_q, ety_hi_d;
    logic [31:0]           crc_q, crc_d;
    logic [13:0]           len_q, len_d;
    logic                  er_seen_q, er_seen_d;
    logic [4:0][7:0]       dl_q, dl_d;
    logic [2:0]            dl_cnt_q, dl_cnt_d;
    logic                  armed_q, armed_d;
    logic [7:0]            m_tdata_q, m_tdata_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;
    logic                  m_tuser_q, m_tuser_d;
    logic [NUM_ETYPES-1:0] etype_hit_q, etype_hit_d;
    logic [47:0]           rx_src_mac_q, rx_src_mac_d;
    logic                  frame_ok_q, frame_ok_d;
    logic                  frame_crc_err_q, frame_crc_err_d;
    logic                  frame_len_err_q, frame_len_err_d;
    logic                  frame_drop_q, frame_drop_d;

    logic [NUM_ETYPES-1:0] hit;
    logic [15:0]           rx_etype;
    logic                  addr_ok;
    logic [31:0]           crc_upd;
    logic [13:0]           len_inc;
    logic                  crc_bad;
    logic                  len_bad;

    // Address and EtherType match, evaluated while the last header byte is on the bus.
    always_comb begin
        rx_etype = {ety_hi_q, gmii_rxd};
        hit      = '0;
        for (int k = 0; k < int'(NUM_ETYPES); k++) begin
            hit[k] = (etype_table[16*k +: 16] != 16'h0000) &&
                     (etype_table[16*k +: 16] == rx_etype);
        end
        addr_ok = promisc_en || (dest_q == mac_d_addr) || (dest_q == 48'hFFFF_FFFF_FFFF);
    end

    // Frame FSM next state, datapath updates and registered output values.
    always_comb begin
        state_d         = state_q;
        pre_cnt_d       = pre_cnt_q;
        hdr_cnt_d       = hdr_cnt_q;
        dest_d          = dest_q;
        src_d           = src_q;
        ety_hi_d        = ety_hi_q;
        crc_d           = crc_q;
        len_d           = len_q;
        er_seen_d       = er_seen_q;
        dl_d            = dl_q;
        dl_cnt_d        = dl_cnt_q;
        // Only start a frame once dv has been seen low since reset.
        armed_d         = armed_q | ~gmii_rx_dv;
        m_tdata_d       = m_tdata_q;
        m_tvalid_d      = 1'b0;
        m_tlast_d       = 1'b0;
        m_tuser_d       = 1'b0;
        etype_hit_d     = etype_hit_q;
        rx_src_mac_d    = rx_src_mac_q;
        frame_ok_d      = 1'b0;
        frame_crc_err_d = 1'b0;
        frame_len_err_d = 1'b0;
        frame_drop_d    = 1'b0;

        crc_upd = crc_byte(crc_q, gmii_rxd);
        len_inc = (len_q == LenSat) ? len_q : len_q + 14'd1;
        crc_bad = (crc_q != CrcResidue);
        len_bad = (len_q < MinLen) || (len_q > MaxLen);

        unique case (state_q)
            StIdle: begin
                if (gmii_rx_dv) begin
                    if (armed_q && gmii_rxd == 8'h55) begin
                        state_d   = StPreamble;
                        pre_cnt_d = 3'd1;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StPreamble: begin
                if (!gmii_rx_dv) begin
                    state_d = StIdle;
                end else if (gmii_rxd == 8'h55) begin
                    if (pre_cnt_q == 3'd7) state_d = StDrop;
                    else pre_cnt_d = pre_cnt_q + 3'd1;
                end else if (gmii_rxd == 8'hD5) begin
                    state_d   = StHeader;
                    hdr_cnt_d = 4'd0;
                    crc_d     = 32'hFFFF_FFFF;
                    len_d     = 14'd0;
                    er_seen_d = 1'b0;
                    dl_cnt_d  = 3'd0;
                end else begin
                    state_d = StDrop;
                end
            end
            StHeader: begin
                if (!gmii_rx_dv) begin
                    state_d         = StIdle;
                    frame_len_err_d = 1'b1;
                end else begin
                    crc_d     = crc_upd;
                    len_d     = len_inc;
                    er_seen_d = er_seen_q | gmii_rx_er;
                    hdr_cnt_d = hdr_cnt_q + 4'd1;
                    if (hdr_cnt_q < 4'd6) begin
                        dest_d = {dest_q[39:0], gmii_rxd};
                    end else if (hdr_cnt_q < 4'd12) begin
                        src_d = {src_q[39:0], gmii_rxd};
                    end else if (hdr_cnt_q == 4'd12) begin
                        ety_hi_d = gmii_rxd;
                    end else if (addr_ok && (hit != '0)) begin
                        state_d      = StPayload;
                        etype_hit_d  = hit;
                        rx_src_mac_d = src_q;
                    end else begin
                        state_d      = StDrop;
                        frame_drop_d = 1'b1;
                    end
                end
            end
            StPayload: begin
                if (gmii_rx_dv) begin
                    crc_d     = crc_upd;
                    len_d     = len_inc;
                    er_seen_d = er_seen_q | gmii_rx_er;
                    dl_d      = {dl_q[3:0], gmii_rxd};
                    if (dl_cnt_q == 3'd5) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = dl_q[4];
                    end else begin
                        dl_cnt_d = dl_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = StIdle;
                    // The four younger entries are the FCS and are discarded.
                    if (dl_cnt_q == 3'd5) begin
                        m_tvalid_d = 1'b1;
                        m_tlast_d  = 1'b1;
                        m_tdata_d  = dl_q[4];
                        m_tuser_d  = crc_bad | len_bad | er_seen_q;
                        if (len_bad) frame_len_err_d = 1'b1;
                        else if (crc_bad || er_seen_q) frame_crc_err_d = 1'b1;
                        else frame_ok_d = 1'b1;
                    end else begin
                        frame_len_err_d = 1'b1;
                    end
                end
            end
            StDrop: begin
                if (!gmii_rx_dv) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= StIdle;
            pre_cnt_q       <= '0;
            hdr_cnt_q       <= '0;
            dest_q          <= '0;
            src_q           <= '0;
            ety_hi_q        <= '0;
            crc_q           <= 32'hFFFF_FFFF;
            len_q           <= '0;
            er_seen_q       <= 1'b0;
            dl_q            <= '0;
            dl_cnt_q        <= '0;
            armed_q         <= 1'b0;
            m_tdata_q       <= '0;
            m_tvalid_q      <= 1'b0;
            m_tlast_q       <= 1'b0;
            m_tuser_q       <= 1'b0;
            etype_hit_q     <= '0;
            rx_src_mac_q    <= '0;
            frame_ok_q      <= 1'b0;
            frame_crc_err_q <= 1'b0;
            frame_len_err_q <= 1'b0;
            frame_drop_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            pre_cnt_q       <= pre_cnt_d;
            hdr_cnt_q       <= hdr_cnt_d;
            dest_q          <= dest_d;
            src_q           <= src_d;
            ety_hi_q        <= ety_hi_d;
            crc_q           <= crc_d;
            len_q           <= len_d;
            er_seen_q       <= er_seen_d;
            dl_q            <= dl_d;
            dl_cnt_q        <= dl_cnt_d;
            armed_q         <= armed_d;
            m_tdata_q       <= m_tdata_d;
            m_tvalid_q      <= m_tvalid_d;
            m_tlast_q       <= m_tlast_d;
            m_tuser_q       <= m_tuser_d;
            etype_hit_q     <= etype_hit_d;
            rx_src_mac_q    <= rx_src_mac_d;
            frame_ok_q      <= frame_ok_d;
            frame_crc_err_q <= frame_crc_err_d;
            frame_len_err_q <= frame_len_err_d;
            frame_drop_q    <= frame_drop_d;
        end
    end

    assign m_tdata       = m_tdata_q;
    assign m_tvalid      = m_tvalid_q;
    assign m_tlast       = m_tlast_q;
    assign m_tuser       = m_tuser_q;
    assign etype_hit     = etype_hit_q;
    assign rx_src_mac    = rx_src_mac_q;
    assign frame_ok      = frame_ok_q;
    assign frame_crc_err = frame_crc_err_q;
    assign frame_len_err = frame_len_err_q;
    assign frame_drop    = frame_drop_q;

endmodule

// File: doc/eth_rx_frame_filter.md
Name: eth_rx_frame_filter

Overview:
- Parametrised GMII receive frame engine, one byte per clock. Replaces the fixed ARP/IP-only header path in the receive top.
- Detects preamble/SFD, parses the Ethernet header and filters on destination MAC. Classifies the EtherType against a run-time table of NUM_ETYPES entries.
- Streams payload with the FCS stripped, checks CRC-32 and frame length, and tags bad frames on the last beat.
- Feeds the downstream ARP/IP/UDP parsers, which select frames by the one-hot EtherType hit vector.

Parameters:
- NUM_ETYPES, 4, number of EtherType table entries (1..8).
- MIN_FRAME_LEN, 64, minimum legal length in bytes, dest MAC through FCS inclusive (>=19).
- MAX_FRAME_LEN, 1518, maximum legal length, same span (<=16383).

Ports:
- aclk  in  1  receive clock (gmii_rx_clk domain).
- aresetn  in  1  asynchronous active-low reset.
- gmii_rxd  in  8  receive data.
- gmii_rx_dv  in  1  receive data valid.
- gmii_rx_er  in  1  receive error.
- mac_d_addr  in  48  local MAC address; byte 0 of the wire is bits [47:40].
- promisc_en  in  1  accept any destination MAC.
- etype_table  in  16*NUM_ETYPES  entry k in bits [16k+15:16k]; value 16'h0000 disables the entry.
- m_tdata  out  8  payload byte.
- m_tvalid  out  1  payload byte valid. No backpressure: no tready port.
- m_tlast  out  1  last payload byte.
- m_tuser  out  1  frame bad; meaningful only with m_tlast.
- etype_hit  out  NUM_ETYPES  one-hot table match for the current frame.
- rx_src_mac  out  48  source MAC of the current frame.
- frame_ok, frame_crc_err, frame_len_err, frame_drop  out  1 each  one-cycle status pulses.

Behaviour:
- Reset: state IDLE. All outputs are 0, including etype_hit and rx_src_mac. Reset asserted mid-frame aborts immediately with no tlast. After reset, the engine waits for gmii_rx_dv low before accepting a new frame.
- State IDLE:
  - dv=1 and rxd=8'h55 -> PREAMBLE.
  - dv=1 and any other byte -> DROP.
- State PREAMBLE:
  - 8'h55 -> stay; more than 7 consecutive 8'h55 -> DROP.
  - 8'hD5 after at least one 8'h55 -> HEADER. The 14-bit length counter and CRC register (all ones) are cleared here.
  - Any other byte -> DROP.
  - dv=0 -> IDLE, no pulse.
- State HEADER: 14 bytes. Bytes 0-5 are dest MAC, 6-11 source MAC, 12-13 EtherType (big-endian).
  - On byte 13 the frame is accepted if the address check passes and the EtherType check passes.
  - Address check: dest==mac_d_addr, or dest==48'hFFFF_FFFF_FFFF, or promisc_en=1.
  - EtherType check: any enabled entry equals the received EtherType.
  - Accepted -> PAYLOAD. etype_hit and rx_src_mac are registered on this edge and held until the next accepted header.
  - Rejected -> DROP, with frame_drop pulsed once.
  - dv=0 inside HEADER -> IDLE, frame_len_err pulsed, no stream output.
- State PAYLOAD: bytes enter a 5-entry delay line.
  - When dv=1 and 5 entries are held, the oldest entry is driven with m_tvalid=1 on the next cycle. Latency is 5 bytes.
  - First dv=0 sample:
    - If 5 entries are held, emit the oldest with m_tlast=1 and m_tuser=crc_bad|len_bad|er_seen; the remaining 4 entries are the FCS and are discarded.
    - If fewer than 5 are held, emit nothing and pulse frame_len_err.
  - Then -> IDLE.
- State DROP: ignores bytes until dv=0, then -> IDLE.
- CRC-32: reflected polynomial 0xEDB88320, init 32'hFFFF_FFFF, updated over every byte from dest MAC through FCS. crc_bad = (register != 32'hDEBB_20E3) at end of frame.
- Length: counts bytes from dest MAC through FCS and saturates at 16383. len_bad = count<MIN_FRAME_LEN or count>MAX_FRAME_LEN. Over-length frames are still streamed in full.
- er_seen: set by gmii_rx_er=1 with dv=1 in HEADER or PAYLOAD; cleared on SFD.
- Status pulses: exactly one per frame that reaches the SFD, registered in the same cycle as m_tlast where one exists.
  - Precedence: frame_len_err over frame_crc_err over frame_ok.
  - An er_seen frame with good CRC and length pulses frame_crc_err.
- Back-to-back frames: a single dv=0 cycle between frames is sufficient.

Test Plan:
- Good frame: 7x55, D5, dest=mac_d_addr, EtherType 0x0800 = table entry 0, 46-byte payload, valid FCS (L=64) -> 46 m_tvalid beats, the first one 5 cycles after payload byte 0 was sampled; tlast on byte 45; tuser=0; etype_hit=4'b0001; frame_ok pulse.
- Same frame with one FCS bit flipped -> 46 beats, tuser=1, frame_crc_err pulse.
- Broadcast ARP 0x0806 in entry 1 (L=64) -> accepted, etype_hit=4'b0010. Unknown dest 02:00:00:00:00:99 with promisc_en=0 -> no beats, frame_drop pulse. Same frame with promisc_en=1 -> accepted.
- Runt: L=60 with valid CRC -> 42 beats, tuser=1, frame_len_err. L=1519 -> streamed, tuser=1, frame_len_err.
- dv drops after 10 header bytes -> no beats, frame_len_err. gmii_rx_er pulse mid-payload -> tuser=1, frame_crc_err. Back-to-back good frames with 1-cycle gap -> two frame_ok pulses.
- aresetn asserted mid-payload -> all outputs 0 immediately. The next frame starting after dv low is received correctly.
